tb_uart: RTL and testbench
==========================

# tb_uart

Bench-side serial UART model attached to the chip's user UART pins (chip TX on GPIO 6 → `ser_rx`, `ser_tx` → chip RX on GPIO 5). It transmits one byte per request from the verification sequence and receives bytes emitted by firmware running on the chip. It is fully synchronous, 8N1, LSB first, with a parameterised bit period. Implementation is synthesizable RTL so that it can also serve as an on-board loopback/debug UART.

## Interface
- `CLKS_PER_BIT`, default 4167 — clock cycles per serial bit (40 MHz / 9600 baud); minimum 4, even values recommended.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ser_rx`  in  1  serial input from the chip's UART TX; idle high; asynchronous to `clock`.
- `ser_tx`  out  1  serial output to the chip's UART RX; idle high.
- `tx_start`  in  1  level request; a new frame starts on its 0→1 transition.
- `tx_data`  in  8  byte to send; sampled at the cycle the frame starts.
- `tx_busy`  out  1  high while a frame is on `ser_tx`.
- `tx_clear_req`  out  1  high from frame completion until `tx_start` is driven low.
- `rx_data`  out  8  last correctly received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- Reset values: `ser_tx`=1, `tx_busy`=0, `tx_clear_req`=0, `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0. Both FSMs return to IDLE; bit counters and shift registers clear. Reset asserted mid-frame aborts the frame immediately, and `ser_tx` returns high.
- TX FSM states: IDLE → START → DATA(8 bits) → STOP → DONE.
  - IDLE: registered `tx_start_q` tracks `tx_start`. When `tx_start`=1 and `tx_start_q`=0, latch `tx_data`, drive `ser_tx`=0, set `tx_busy`=1, and go to START.
  - START, DATA, STOP: each bit is held for exactly `CLKS_PER_BIT` cycles. Data bits go LSB first, then the stop bit (=1).
  - At the end of STOP: `tx_busy`=0. If `tx_start` is still 1, set `tx_clear_req`=1 and go to DONE; otherwise go to IDLE.
  - DONE: hold `tx_clear_req`=1 until `tx_start`=0, then clear it and go to IDLE.
  - A held-high `tx_start` never re-triggers. Rising edges of `tx_start` while busy or in DONE are ignored and are not queued.
- RX FSM states: IDLE → START → DATA → STOP.
  - `ser_rx` passes through a 2-flop synchroniser that resets to 1.
  - IDLE: a synchronised low starts the frame. Wait `CLKS_PER_BIT/2` cycles, then re-sample. If the line is high again, treat it as a glitch and return to IDLE. If still low, go to DATA.
  - DATA: sample 8 bits at bit centres, `CLKS_PER_BIT` apart, shifting LSB first.
  - STOP: sample one period later. If 1: `rx_data`←byte and pulse `rx_valid`. If 0: pulse `rx_frame_err` and leave `rx_data` unchanged. Then return to IDLE. The next start bit is accepted immediately (no extra idle time required).
- TX and RX are independent and may run simultaneously; loopback of `ser_tx` to `ser_rx` must work.

## Timing
- A `tx_start` rising edge sampled at edge N drives `ser_tx`=0 and `tx_busy`=1 after edge N.
- `tx_busy` is high for exactly `10*CLKS_PER_BIT` cycles. The frame is 10 bits long.
- `tx_clear_req` rises in the same cycle `tx_busy` falls, and falls one cycle after `tx_start` is seen low.
- `rx_valid` / `rx_frame_err` pulse `9.5*CLKS_PER_BIT + 2` (±1) cycles after the start-bit falling edge on `ser_rx`. Each pulse is exactly 1 cycle wide.
- The receiver tolerates ±3% baud mismatch.

## Test plan
- Reset: hold `reset` for 5 cycles with `tx_start`=1 → all outputs at their reset values, `ser_tx`=1. Releasing reset with `tx_start` already high must not start a frame (`tx_start_q` resets to 1).
- TX 0x3D (`CLKS_PER_BIT`=16): raise `tx_start` with `tx_data`=61.
  - `ser_tx` sequence per 16-cycle slot: 0,1,0,1,1,1,1,0,0,1.
  - `tx_busy` high for 160 cycles.
  - `tx_clear_req`=1 afterwards; lower `tx_start` → `tx_clear_req`=0 next cycle.
- Loopback: tie `ser_tx` to `ser_rx` and send 15 then 61 back-to-back, lowering `tx_start` between them → `rx_valid` pulses twice, with `rx_data`=0x0F then 0x3D; `rx_frame_err` never asserts.
- RX frame error: drive a 0xA5 frame on `ser_rx` with the stop bit low → `rx_frame_err` pulses once, `rx_valid` stays 0, `rx_data` unchanged.
- Glitch and retrigger: a 3-cycle low pulse on `ser_rx` → no `rx_valid`. Toggling `tx_start` low→high mid-frame → no second frame; `tx_busy` still totals 160 cycles.
- Reset mid-frame: assert `reset` at cycle 50 of a TX frame → `ser_tx`=1 and `tx_busy`=0 immediately (asynchronously).

Source files
------------

// File: rtl/tb_uart.sv
// 8N1 LSB-first UART with independent TX and RX state machines.
// Parameterised bit period, usable as a bench model or an on-board loopback UART.
module tb_uart #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t       tx_state;
  logic            tx_start_q;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;

  rx_state_t       rx_state;
  logic [1:0]      rx_sync;
  logic            rx_s;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  // tx_start_q resets high so a request already asserted at reset release is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      tx_start_q   <= 1'b1;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      tx_start_q <= tx_start;
      case (tx_state)
        TX_IDLE: begin
          if (tx_start && !tx_start_q) begin
            tx_shift <= tx_data;
            ser_tx   <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            ser_tx   <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              ser_tx   <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              ser_tx   <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
            if (tx_start) begin
              tx_clear_req <= 1'b1;
              tx_state     <= TX_DONE;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DONE: begin
          if (!tx_start) begin
            tx_clear_req <= 1'b0;
            tx_state     <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_s = rx_sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync      <= '1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], ser_rx};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check at mid start bit; a line already back high was a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_uart.sv
// Directed bench for tb_uart at 16 clocks per bit: TX slot table, RX frame table,
// plus glitch, retrigger, loopback and mid-frame reset sequences.
module tb_tb_uart;

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  logic rx_drv;
  logic loop;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   pulse_cyc = 0;
  int   start_cyc = 0;
  logic [7:0] last_data = '0;
  logic [7:0] prev_data = '0;

  assign ser_rx = loop ? ser_tx : rx_drv;

  tb_uart #(.CLKS_PER_BIT(16)) dut (
    .clock(clock), .reset(reset), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid) begin
      valid_cnt++;
      pulse_cyc = cyc;
      prev_data = last_data;
      last_data = rx_data;
    end
    if (rx_frame_err) begin
      err_cnt++;
      pulse_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;      // bit i = expected ser_tx level in slot i
    int         mode;       // 0 hold, 1 release early, 2 toggle mid-frame
    logic       exp_clear;
  } tx_vec_t;

  typedef struct {
    logic [9:0] frame;      // bit i = level driven in slot i
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_rx;
  } rx_vec_t;

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[5];

  task automatic send_frame(input logic [7:0] d, input logic [9:0] frame,
                            input int mode, input logic exp_clear);
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 160; c++) begin
      if (tx_busy) busy_cycles++;
      if (c % 16 == 8)
        check($sformatf("ser_tx data=%0h slot%0d", d, c / 16), 32'(ser_tx), 32'(frame[c / 16]));
      if (c == 159) check("clear_req low while busy", 32'(tx_clear_req), 0);
      if (mode == 1 && c == 20) tx_start = 1'b0;
      if (mode == 2 && c == 40) tx_start = 1'b0;
      if (mode == 2 && c == 41) tx_start = 1'b1;
      @(posedge clock); #1;
    end
    check($sformatf("busy cycles data=%0h", d), 32'(busy_cycles), 160);
    check("busy low after frame", 32'(tx_busy), 0);
    check("clear_req after frame", 32'(tx_clear_req), 32'(exp_clear));
    check("ser_tx idle after frame", 32'(ser_tx), 1);
    @(negedge clock);
    tx_start = 1'b0;
    @(posedge clock); #1;
    check("clear_req after start low", 32'(tx_clear_req), 0);
    repeat (3) @(posedge clock);
    #1;
    check("no retrigger busy", 32'(tx_busy), 0);
  endtask

  task automatic drive_frame(input logic [9:0] frame);
    @(negedge clock);
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (16) @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (24) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, lat;
    tx_tab[0] = '{8'h3D, 10'b1001111010, 0, 1'b1};
    tx_tab[1] = '{8'h00, 10'b1000000000, 1, 1'b0};
    tx_tab[2] = '{8'hFF, 10'b1111111110, 2, 1'b1};
    tx_tab[3] = '{8'h80, 10'b1100000000, 0, 1'b1};
    tx_tab[4] = '{8'h01, 10'b1000000010, 1, 1'b0};
    rx_tab[0] = '{10'b1001111010, 1, 0, 8'h3D};
    rx_tab[1] = '{10'b0101001010, 0, 1, 8'h3D};
    rx_tab[2] = '{10'b1000000000, 1, 0, 8'h00};
    rx_tab[3] = '{10'b1111111110, 1, 0, 8'hFF};
    rx_tab[4] = '{10'b1010101010, 1, 0, 8'h55};

    reset = 1'b1; tx_start = 1'b1; tx_data = '0; rx_drv = 1'b1; loop = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("reset ser_tx", 32'(ser_tx), 1);
    check("reset tx_busy", 32'(tx_busy), 0);
    check("reset clear_req", 32'(tx_clear_req), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset rx_frame_err", 32'(rx_frame_err), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("held start after reset busy", 32'(tx_busy), 0);
    check("held start after reset ser_tx", 32'(ser_tx), 1);
    @(negedge clock);
    tx_start = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 5; i++)
      send_frame(tx_tab[i].data, tx_tab[i].frame, tx_tab[i].mode, tx_tab[i].exp_clear);

    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      drive_frame(rx_tab[i].frame);
      check($sformatf("rx_valid pulses vec%0d", i), 32'(valid_cnt - v0), 32'(rx_tab[i].exp_valid));
      check($sformatf("rx_frame_err pulses vec%0d", i), 32'(err_cnt - e0), 32'(rx_tab[i].exp_err));
      check($sformatf("rx_data vec%0d", i), 32'(rx_data), 32'(rx_tab[i].exp_rx));
      lat = pulse_cyc - start_cyc;
      check($sformatf("rx latency vec%0d (%0d cycles)", i, lat), 32'(lat >= 153 && lat <= 155), 1);
    end

    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (3) @(negedge clock);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch rx_valid", 32'(valid_cnt - v0), 0);
    check("glitch rx_frame_err", 32'(err_cnt - e0), 0);
    check("glitch rx_data", 32'(rx_data), 32'h55);

    loop = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h0F, 10'b1000011110, 0, 1'b1);
    send_frame(8'h3D, 10'b1001111010, 0, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    check("loopback rx_valid pulses", 32'(valid_cnt - v0), 2);
    check("loopback first byte", 32'(prev_data), 32'h0F);
    check("loopback second byte", 32'(last_data), 32'h3D);
    check("loopback frame_err", 32'(err_cnt - e0), 0);
    loop = 1'b0;

    @(negedge clock);
    tx_data = 8'h00; tx_start = 1'b1;
    @(posedge clock);
    repeat (50) @(posedge clock);
    #1;
    check("mid-frame ser_tx before reset", 32'(ser_tx), 0);
    check("mid-frame busy before reset", 32'(tx_busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset ser_tx", 32'(ser_tx), 1);
    check("async reset tx_busy", 32'(tx_busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("post reset no frame busy", 32'(tx_busy), 0);
    check("post reset rx_data", 32'(rx_data), 0);
    @(negedge clock);
    tx_start = 1'b0;
    repeat (2) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
